// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the pipeline stall/flush scheduler.
// Exception-drain FSM encoding, divide latency default, stage indices.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_DRAIN = 2'd1,
    HZ_EXC   = 2'd2
  } hz_state_e;

  localparam int DIV_CYCLES_DEF = 32;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

endpackage

// File: rtl/hz_div_counter.sv
// Divide-latency down-counter: load, freeze on memory stall, clear on exception.
// busy is high while any divide cycles remain.
module hz_div_counter #(
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic freeze,
  input  logic clear,
  output logic busy
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DIV_CYCLES - 1);
    end else if (!freeze && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_sched
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CW         = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        load_use,
  input  logic        br_redirect,
  input  logic        div_start,
  input  logic        exc_valid,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        stall_w,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        pc_sel_exc,
  output logic        div_busy,
  output logic [1:0]  fsm_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_div_stall,
  output logic [31:0] perf_flush
`endif
);

  hz_state_e  state;
  logic [4:0] stall;
  logic [4:0] flush;
  logic       div_load;

  assign stall_f = stall[STG_F];
  assign stall_d = stall[STG_D];
  assign stall_e = stall[STG_E];
  assign stall_m = stall[STG_M];
  assign stall_w = stall[STG_W];
  assign flush_d = flush[STG_D];
  assign flush_e = flush[STG_E];
  assign flush_m = flush[STG_M];
  assign flush_w = flush[STG_W];
  assign fsm_state = state;

  // Only the highest-priority source drives stalls and flushes in RUN.
  always_comb begin
    stall      = '0;
    flush      = '0;
    pc_sel_exc = 1'b0;
    if (!rst) begin
      flush[STG_D] = 1'b1;
      flush[STG_E] = 1'b1;
      flush[STG_M] = 1'b1;
      flush[STG_W] = 1'b1;
    end else if (state == HZ_DRAIN) begin
      stall[STG_M:STG_F] = 4'hF;
      flush[STG_W]       = 1'b1;
    end else if (state == HZ_EXC) begin
      flush[STG_D] = 1'b1;
      flush[STG_E] = 1'b1;
      flush[STG_M] = 1'b1;
      flush[STG_W] = 1'b1;
      pc_sel_exc   = 1'b1;
    end else if (exc_valid) begin
      stall = '0;
    end else if (mem_busy) begin
      stall[STG_M:STG_F] = 4'hF;
      flush[STG_W]       = 1'b1;
    end else if (div_busy) begin
      stall[STG_E:STG_F] = 3'h7;
      flush[STG_M]       = 1'b1;
    end else if (load_use) begin
      stall[STG_D:STG_F] = 2'h3;
      flush[STG_E]       = 1'b1;
    end else if (if_busy) begin
      stall[STG_F] = 1'b1;
      flush[STG_D] = 1'b1;
    end else if (br_redirect) begin
      flush[STG_D] = 1'b1;
    end
  end

  assign div_load = (state == HZ_RUN) && div_start && !stall[STG_E];

  hz_div_counter #(
    .DIV_CYCLES (DIV_CYCLES),
    .CW         (CW)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .load   (div_load),
    .freeze (mem_busy),
    .clear  (state == HZ_EXC),
    .busy   (div_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HZ_RUN;
    end else begin
      unique case (state)
        HZ_RUN:   if (exc_valid) state <= mem_busy ? HZ_DRAIN : HZ_EXC;
        HZ_DRAIN: if (!mem_busy) state <= HZ_EXC;
        HZ_EXC:   state <= HZ_RUN;
        default:  state <= HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // stall_m is unique to mem/drain; stall_e without stall_m is the div pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mem_stall <= '0;
      perf_div_stall <= '0;
      perf_flush     <= '0;
    end else begin
      if (stall[STG_M] && perf_mem_stall != '1)
        perf_mem_stall <= perf_mem_stall + 32'd1;
      if (stall[STG_E] && !stall[STG_M] && perf_div_stall != '1)
        perf_div_stall <= perf_div_stall + 32'd1;
      if ((|flush) && perf_flush != '1)
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Bench for pipe_hazard_sched: directed scenarios plus random stimulus
// checked against a behavioural model of the scheduling rules.
module tb_pipe_hazard_sched;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst, if_busy, mem_busy, load_use, br_redirect, div_start, exc_valid;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w;
  logic pc_sel_exc, div_busy;
  logic [1:0] fsm_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_mem_stall, perf_div_stall, perf_flush;
  int pm, pd, pf;
`endif

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int dleft = 0;
  int n;

  always #5 clk = ~clk;

  pipe_hazard_sched #(.DIV_CYCLES(DC), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .if_busy(if_busy), .mem_busy(mem_busy), .load_use(load_use),
    .br_redirect(br_redirect), .div_start(div_start), .exc_valid(exc_valid),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .pc_sel_exc(pc_sel_exc), .div_busy(div_busy), .fsm_state(fsm_state)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_mem_stall(perf_mem_stall), .perf_div_stall(perf_div_stall),
    .perf_flush(perf_flush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare at +1, advance model for posedge.
  task automatic step(input logic r, ifb, mb, lu, br, ds, ex);
    logic [4:0] es;
    logic [3:0] ef;
    logic ep;
    int pat;
    @(negedge clk);
    rst = r; if_busy = ifb; mem_busy = mb; load_use = lu;
    br_redirect = br; div_start = ds; exc_valid = ex;
    #1;
    if (!r) begin
      mode = 0; dleft = 0;
`ifdef HAZARD_PERF_CNT_EN
      pm = 0; pd = 0; pf = 0;
`endif
    end
    es = '0; ef = '0; ep = 1'b0; pat = 0;
    if (!r) ef = 4'hF;
    else if (mode == 1) begin es = 5'b11110; ef = 4'b0001; pat = 1; end
    else if (mode == 2) begin ef = 4'hF; ep = 1'b1; end
    else if (ex) pat = 0;
    else if (mb) begin es = 5'b11110; ef = 4'b0001; pat = 1; end
    else if (dleft > 0) begin es = 5'b11100; ef = 4'b0010; pat = 2; end
    else if (lu) begin es = 5'b11000; ef = 4'b0100; end
    else if (ifb) begin es = 5'b10000; ef = 4'b1000; end
    else if (br) ef = 4'b1000;
    chk("stall", {stall_f, stall_d, stall_e, stall_m, stall_w}, es);
    chk("flush", {flush_d, flush_e, flush_m, flush_w}, ef);
    chk("pc_sel_exc", pc_sel_exc, ep);
    chk("div_busy", div_busy, dleft > 0);
    chk("fsm_state", fsm_state, mode);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_mem", perf_mem_stall, pm);
    chk("perf_div", perf_div_stall, pd);
    chk("perf_flush", perf_flush, pf);
    if (r) begin
      if (pat == 1) pm++;
      if (pat == 2) pd++;
      if (ef != 0) pf++;
    end
`endif
    if (r) begin
      if (mode == 2) dleft = 0;
      else if (mode == 0 && ds && !es[2]) dleft = DC - 1;
      else if (dleft > 0 && !mb) dleft--;
      case (mode)
        0: if (ex) mode = mb ? 1 : 2;
        1: if (!mb) mode = 2;
        default: mode = 0;
      endcase
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0; if_busy = 0; mem_busy = 0; load_use = 0;
    br_redirect = 0; div_start = 0; exc_valid = 0;
    repeat (3) step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
    step(1, 1, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 1, 0, 0, 0);
    idle();

    n = 0;
    step(1, 0, 0, 0, 0, 1, 0);
    repeat (8) begin idle(); n += int'(div_busy); end
    chk("div_len", n, 3);

    n = 0;
    step(1, 0, 0, 0, 0, 1, 0);
    idle(); n += int'(div_busy);
    repeat (2) begin step(1, 0, 1, 0, 0, 0, 0); n += int'(div_busy); end
    repeat (6) begin idle(); n += int'(div_busy); end
    chk("div_len_mem", n, 5);

    n = 0;
    step(1, 0, 1, 0, 0, 0, 1);
    repeat (3) begin step(1, 0, 1, 0, 0, 0, 0); n += int'(fsm_state == 2'd1); end
    chk("drain_len", n, 3);
    idle(); idle(); idle();

    step(1, 0, 0, 0, 0, 1, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 1);
    idle(); idle();
    chk("div_after_exc", div_busy, 1'b0);

    repeat (2) step(1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    idle();

    repeat (3000) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
